// File: rtl/acc_pkg.sv
// Shared definitions for the column-sum accumulator datapath and its control.
// Widths here are the defaults used by the accumulator, the output buffer and
// acc_sequencer so that all three agree on address and count sizes.
package acc_pkg;

    localparam int ACC_ADDR_W    = 4;   // output-buffer address width
    localparam int ACC_CNT_W     = 8;   // partial-sum beat counter width
    localparam int ACC_OUT_W     = 5;   // outputs-per-tile count width
    localparam int BFP32_ADD_LAT = 2;   // bfp32_adder pipeline depth

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_STORE = 3'd4,
        ST_FIN   = 3'd5
    } acc_state_t;

    // Width needed to hold a drain count of lat-1 (at least one bit).
    function automatic int drain_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/acc_sequencer.sv
// acc_sequencer: sequences the column-sum accumulator for one output tile.
// For each output it clears the accumulator, counts num_psums partial-sum
// beats, waits ADD_LAT cycles for the adder chain to settle, then pulses
// store_output with the output-buffer address.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               tile request, honoured only in IDLE
//   num_psums           beats per output       (latched on accepted start)
//   num_outputs         outputs per tile       (latched on accepted start)
//   base_addr           first buffer address   (latched on accepted start)
//   psum_valid          one partial-sum beat present this cycle
//   acc_reset           accumulator clear pulse          (registered)
//   store_output        accumulator result write strobe  (registered)
//   op_buffer_address   write address, held between stores (registered)
//   busy                tile in progress                 (registered)
//   done                tile completion pulse            (registered)
//   overrun             beat arrived outside ACCUM       (registered)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// CLEAR | acc_reset asserted, beat counter cleared
// ACCUM | counting psum_valid beats until num_psums seen
// DRAIN | waiting ADD_LAT cycles for the adder chain result
// STORE | store_output asserted, address and output count advance
// FIN   | done pulse, back to IDLE
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int ADDR_W  = ACC_ADDR_W,
    parameter int CNT_W   = ACC_CNT_W,
    parameter int OUT_W   = ACC_OUT_W,
    parameter int ADD_LAT = BFP32_ADD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_psums,
    input  logic [OUT_W-1:0]  num_outputs,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              psum_valid,
    output logic              acc_reset,
    output logic              store_output,
    output logic [ADDR_W-1:0] op_buffer_address,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int DRN_W = drain_w(ADD_LAT);

    acc_state_t        state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_nxt;
    logic [CNT_W-1:0]  npsum_q, npsum_nxt;
    logic [DRN_W-1:0]  drain_cnt, drain_nxt;
    logic [OUT_W-1:0]  out_cnt, out_nxt;
    logic [OUT_W-1:0]  nout_q, nout_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] op_addr_nxt;
    logic              acc_reset_nxt, store_nxt, busy_nxt, done_nxt, overrun_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            beat_cnt          <= '0;
            npsum_q           <= '0;
            drain_cnt         <= '0;
            out_cnt           <= '0;
            nout_q            <= '0;
            addr              <= '0;
            acc_reset         <= 1'b0;
            store_output      <= 1'b0;
            op_buffer_address <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            state             <= state_nxt;
            beat_cnt          <= beat_nxt;
            npsum_q           <= npsum_nxt;
            drain_cnt         <= drain_nxt;
            out_cnt           <= out_nxt;
            nout_q            <= nout_nxt;
            addr              <= addr_nxt;
            acc_reset         <= acc_reset_nxt;
            store_output      <= store_nxt;
            op_buffer_address <= op_addr_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
            overrun           <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        npsum_nxt = npsum_q;
        drain_nxt = drain_cnt;
        out_nxt   = out_cnt;
        nout_nxt  = nout_q;
        addr_nxt  = addr;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (num_psums == '0 || num_outputs == '0) begin
                        state_nxt = ST_FIN;
                    end else begin
                        npsum_nxt = num_psums;
                        nout_nxt  = num_outputs;
                        addr_nxt  = base_addr;
                        out_nxt   = '0;
                        state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                beat_nxt  = '0;
                state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (psum_valid) begin
                    beat_nxt = beat_cnt + CNT_W'(1);
                    if (beat_cnt == npsum_q - CNT_W'(1)) begin
                        drain_nxt = DRN_W'(ADD_LAT - 1);
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = ST_STORE;
                end else begin
                    drain_nxt = drain_cnt - DRN_W'(1);
                end
            end
            ST_STORE: begin
                addr_nxt = addr + ADDR_W'(1);
                out_nxt  = out_cnt + OUT_W'(1);
                if (out_cnt + OUT_W'(1) == nout_q) begin
                    state_nxt = ST_FIN;
                end else begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the
        // state they describe once registered.
        acc_reset_nxt = (state_nxt == ST_CLEAR);
        store_nxt     = (state_nxt == ST_STORE);
        busy_nxt      = (state_nxt == ST_CLEAR) || (state_nxt == ST_ACCUM) ||
                        (state_nxt == ST_DRAIN) || (state_nxt == ST_STORE);
        done_nxt      = (state_nxt == ST_FIN);
        overrun_nxt   = psum_valid && (state != ST_ACCUM);
        // STORE is only entered from DRAIN, where addr is already final.
        op_addr_nxt   = (state_nxt == ST_STORE) ? addr : op_buffer_address;
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: an event-schedule model predicts
// every registered output each cycle; directed runs pin the model with
// hand-computed expectations; a long random run follows.
module tb_acc_sequencer;

    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 8;
    localparam int OUT_W   = 5;
    localparam int ADD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_psums;
    logic [OUT_W-1:0]  num_outputs;
    logic [ADDR_W-1:0] base_addr;
    logic              psum_valid;
    logic              acc_reset;
    logic              store_output;
    logic [ADDR_W-1:0] op_buffer_address;
    logic              busy;
    logic              done;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    acc_sequencer #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .OUT_W  (OUT_W),
        .ADD_LAT(ADD_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_psums        (num_psums),
        .num_outputs      (num_outputs),
        .base_addr        (base_addr),
        .psum_valid       (psum_valid),
        .acc_reset        (acc_reset),
        .store_output     (store_output),
        .op_buffer_address(op_buffer_address),
        .busy             (busy),
        .done             (done),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: schedule of edge numbers ----------
    int e          = 0;
    int clear_at   = -100;
    int open_at    = -100;
    int store_at   = -100;
    int done_at    = -100;
    int beats_left = 0;
    int outs_left  = 0;
    int np_m       = 0;
    int addr_m     = 0;
    bit m_busy     = 0;
    bit win_open   = 0;
    bit exp_ar, exp_st, exp_busy, exp_done, exp_ov;
    int exp_addr   = 0;

    initial begin : model_and_compare
        bit idle_before, open_before;
        forever begin
            @(posedge clk);
            e++;
            if (rst) begin
                clear_at = -100; open_at = -100; store_at = -100; done_at = -100;
                beats_left = 0; outs_left = 0; m_busy = 0; win_open = 0;
                exp_ar = 0; exp_st = 0; exp_busy = 0; exp_done = 0; exp_ov = 0;
                exp_addr = 0;
            end else begin
                idle_before = !m_busy && (done_at != e - 1);
                open_before = win_open;
                exp_ar = 0; exp_st = 0; exp_done = 0;
                exp_ov = psum_valid && !open_before;
                if (idle_before && start) begin
                    if (num_psums == 0 || num_outputs == 0) begin
                        done_at = e;
                    end else begin
                        np_m      = num_psums;
                        outs_left = num_outputs;
                        addr_m    = base_addr;
                        clear_at  = e;
                        m_busy    = 1;
                    end
                end
                if (open_before && psum_valid) begin
                    beats_left--;
                    if (beats_left == 0) begin
                        win_open = 0;
                        store_at = e + ADD_LAT;
                    end
                end
                if (e == store_at) begin
                    exp_st   = 1;
                    exp_addr = addr_m;
                    addr_m   = (addr_m + 1) % (1 << ADDR_W);
                    outs_left--;
                    if (outs_left == 0) done_at = e + 1;
                    else clear_at = e + 1;
                end
                if (e == clear_at) begin
                    exp_ar     = 1;
                    beats_left = np_m;
                    open_at    = e + 1;
                end
                if (e == open_at) win_open = 1;
                if (e == done_at) begin
                    exp_done = 1;
                    m_busy   = 0;
                end
                exp_busy = m_busy;
            end
            #4;
            chk("acc_reset", acc_reset, exp_ar);
            chk("store_output", store_output, exp_st);
            chk("op_buffer_address", op_buffer_address, exp_addr);
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("overrun", overrun, exp_ov);
        end
    end

    // ---------------- directed run recorder --------------------------------
    logic rec_ar[64], rec_st[64], rec_busy[64], rec_done[64], rec_ov[64];
    int   rec_addr[64];
    int   n_ar, n_st, n_busy, n_done, n_ov;
    int   st_addrs[$];

    // Index k holds the outputs seen during cycle k; start and valid for
    // cycle k come from bit k of the masks.
    task automatic run(input int n, input int np, input int no, input int base,
                       input logic [63:0] smask, input logic [63:0] vmask);
        n_ar = 0; n_st = 0; n_busy = 0; n_done = 0; n_ov = 0;
        st_addrs.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rec_ar[k]   = acc_reset;
            rec_st[k]   = store_output;
            rec_busy[k] = busy;
            rec_done[k] = done;
            rec_ov[k]   = overrun;
            rec_addr[k] = int'(op_buffer_address);
            n_ar   += int'(acc_reset);
            n_st   += int'(store_output);
            n_busy += int'(busy);
            n_done += int'(done);
            n_ov   += int'(overrun);
            if (store_output) st_addrs.push_back(int'(op_buffer_address));
            start       = smask[k];
            psum_valid  = vmask[k];
            num_psums   = CNT_W'(np);
            num_outputs = OUT_W'(no);
            base_addr   = (k == 0) ? ADDR_W'(base) : ADDR_W'(base + 3);
        end
        @(negedge clk);
        start = 0;
        psum_valid = 0;
    endtask

    initial begin : driver
        rst = 1; start = 0; psum_valid = 0;
        num_psums = '0; num_outputs = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_acc_reset", acc_reset, 0);
        chk("reset_busy", busy, 0);
        chk("reset_addr", op_buffer_address, 0);
        rst = 0;

        // Reset mid-ACCUM: two of four beats, then reset.
        run(4, 4, 2, 3, 64'h1, 64'hC);
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_acc_reset", acc_reset, 0);
        chk("midrst_store", store_output, 0);
        chk("midrst_done", done, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_no_store_before", n_st, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Single output, continuous valid, base 5.
        run(12, 3, 1, 5, 64'h1, 64'h1C);
        chk("t2_acc_reset_c1", rec_ar[1], 1);
        chk("t2_busy_c1", rec_busy[1], 1);
        chk("t2_store_c6", rec_st[6], 0);
        chk("t2_store_c7", rec_st[7], 1);
        chk("t2_addr_c7", rec_addr[7], 5);
        chk("t2_done_c8", rec_done[8], 1);
        chk("t2_busy_c8", rec_busy[8], 0);
        chk("t2_done_count", n_done, 1);

        // Zero config.
        run(5, 0, 3, 2, 64'h1, 64'h0);
        chk("zero_done_c1", rec_done[1], 1);
        chk("zero_acc_reset_count", n_ar, 0);
        chk("zero_store_count", n_st, 0);
        chk("zero_busy_count", n_busy, 0);

        // Gapped valid: beats at cycles 2,4,6,8 -> store at 11.
        run(14, 4, 1, 7, 64'h1, 64'h154);
        chk("gap_store_c10", rec_st[10], 0);
        chk("gap_store_c11", rec_st[11], 1);
        chk("gap_addr_c11", rec_addr[11], 7);
        chk("gap_overrun_count", n_ov, 0);
        chk("gap_done_c12", rec_done[12], 1);

        // Address wrap across four outputs.
        run(32, 2, 4, 14, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_store_count", n_st, 4);
        chk("wrap_acc_reset_count", n_ar, 4);
        chk("wrap_done_count", n_done, 1);
        if (st_addrs.size() == 4) begin
            chk("wrap_addr0", st_addrs[0], 14);
            chk("wrap_addr1", st_addrs[1], 15);
            chk("wrap_addr2", st_addrs[2], 0);
            chk("wrap_addr3", st_addrs[3], 1);
        end

        // Start while busy (cycle 3, other base) and a beat during DRAIN (cycle 5).
        run(12, 3, 1, 9, 64'h9, 64'h3C);
        chk("prot_overrun_c6", rec_ov[6], 1);
        chk("prot_overrun_count", n_ov, 1);
        chk("prot_store_c7", rec_st[7], 1);
        chk("prot_addr_c7", rec_addr[7], 9);
        chk("prot_done_c8", rec_done[8], 1);
        chk("prot_store_count", n_st, 1);

        // Random traffic, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 499) == 0);
            start       = ($urandom_range(0, 5) == 0);
            psum_valid  = ($urandom_range(0, 9) < 6);
            num_psums   = ($urandom_range(0, 7) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 5));
            num_outputs = OUT_W'($urandom_range(0, 4));
            base_addr   = ADDR_W'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 0; start = 0; psum_valid = 0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
